seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-segment 7-segment display. It drives one digit at a time, one-hot, with a programmable on-time and a blanking guard interval between digits. It decodes the selected nibble to active-low segments. A 16-bit value is accepted through a valid/ready handshake and is applied only at frame boundaries, so a frame never shows digits from two different values.

---
 rtl/seg7_scan_ctrl_if.sv | 9 +
 rtl/seg7_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - value handshake bundle for the 7-segment scan controller
interface seg7_scan_ctrl_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit 7-segment scan controller with frame-aligned value updates
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 1 always shown).
module seg7_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    seg7_scan_ctrl_if.slave   dbus,
    output logic [6:0]        seg,
    output logic              led1,
    output logic              led2,
    output logic              led3,
    output logic              led4,
    output logic              frame_done
);

    localparam int CMAX = (CLK_DIV > GUARD_CYCLES) ? CLK_DIV : GUARD_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic {DRIVE, GUARD} state_t;

    state_t          state_q, state_n;
    logic [1:0]      digit_q, digit_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            act_q, act_n;
    logic [15:0]     shadow_q, shadow_n;
    logic [15:0]     pend_q;
    logic            full_q;
    logic            commit;
    logic            fd_n;
    logic            blank_n;
    logic            show_n;
    logic [15:0]     shifted;
    logic [6:0]      seg_n;
    logic [3:0]      leds_n;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign dbus.data_ready = !full_q;

    // State registers describe the cycle currently on the display; act_q is low
    // after reset or while disabled so the first enabled edge starts digit 1 at count 0.
    always_comb begin
        state_n = state_q;
        digit_n = digit_q;
        cnt_n   = cnt_q;
        act_n   = act_q;
        fd_n    = 1'b0;
        if (!en) begin
            act_n   = 1'b0;
            state_n = DRIVE;
            digit_n = 2'd0;
            cnt_n   = '0;
        end else if (!act_q) begin
            act_n   = 1'b1;
            state_n = DRIVE;
            digit_n = 2'd0;
            cnt_n   = '0;
        end else begin
            case (state_q)
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        cnt_n = '0;
                        if (GUARD_CYCLES > 0) state_n = GUARD;
                        else                  digit_n = digit_q + 2'd1;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_n   = '0;
                        state_n = DRIVE;
                        digit_n = digit_q + 2'd1;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            endcase
        end
        if (act_n && digit_n == 2'd3) begin
            if (GUARD_CYCLES > 0) fd_n = (state_n == GUARD) && (cnt_n == GUARD_LAST);
            else                  fd_n = (state_n == DRIVE) && (cnt_n == DRIVE_LAST);
        end
    end

    // Commit at the edge closing the frame_done cycle so digit 1 of the next frame
    // already shows the new value; while disabled the pending value goes straight in.
    always_comb begin
        commit   = full_q && (frame_done || !en);
        shadow_n = commit ? pend_q : shadow_q;
        shifted  = shadow_n >> {digit_n, 2'b00};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        case (digit_n)
            2'd1:    blank_n = (shadow_n[15:4] == 12'h000);
            2'd2:    blank_n = (shadow_n[15:8] == 8'h00);
            2'd3:    blank_n = (shadow_n[15:12] == 4'h0);
            default: blank_n = 1'b0;
        endcase
`else
        blank_n = 1'b0;
`endif
        show_n = act_n && (state_n == DRIVE) && !blank_n;
        seg_n  = show_n ? decode(shifted[3:0]) : 7'b1111111;
        leds_n = show_n ? (4'b0001 << digit_n) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DRIVE;
            digit_q    <= 2'd0;
            cnt_q      <= '0;
            act_q      <= 1'b0;
            shadow_q   <= 16'h0000;
            pend_q     <= 16'h0000;
            full_q     <= 1'b0;
            seg        <= 7'b1111111;
            led1       <= 1'b0;
            led2       <= 1'b0;
            led3       <= 1'b0;
            led4       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            digit_q    <= digit_n;
            cnt_q      <= cnt_n;
            act_q      <= act_n;
            shadow_q   <= shadow_n;
            seg        <= seg_n;
            led1       <= leds_n[0];
            led2       <= leds_n[1];
            led3       <= leds_n[2];
            led4       <= leds_n[3];
            frame_done <= fd_n;
            if (commit) full_q <= 1'b0;
            if (dbus.data_valid && !full_q) begin
                pend_q <= dbus.data_in;
                full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl (guarded and guard-free builds)
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        dv  = 1'b0;
    logic [15:0] din = 16'h0000;

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;

    seg7_scan_ctrl_if bus_a ();
    seg7_scan_ctrl_if bus_b ();
    assign bus_a.data_in    = din;
    assign bus_a.data_valid = dv;
    assign bus_b.data_in    = din;
    assign bus_b.data_valid = dv;

    logic [6:0] seg_a, seg_b;
    logic [3:0] leds_a, leds_b;
    logic       fd_a, fd_b;

    seg7_scan_ctrl #(.CLK_DIV(4), .GUARD_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .dbus(bus_a.slave), .seg(seg_a),
        .led1(leds_a[0]), .led2(leds_a[1]), .led3(leds_a[2]), .led4(leds_a[3]),
        .frame_done(fd_a)
    );

    seg7_scan_ctrl #(.CLK_DIV(3), .GUARD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .dbus(bus_b.slave), .seg(seg_b),
        .led1(leds_b[0]), .led2(leds_b[1]), .led3(leds_b[2]), .led4(leds_b[3]),
        .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cd;
        int          gc;
        int          p;
        bit          act;
        bit          full;
        bit          fd;
        logic [15:0] shadow;
        logic [15:0] pend;
        logic [6:0]  seg;
        logic [3:0]  leds;
    } mdl_t;

    mdl_t ma, mb;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'b1000000;  4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;  4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;  4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;  4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;  4'h9: dec = 7'b0010000;
            4'hA: dec = 7'b0001000;  4'hB: dec = 7'b0000011;
            4'hC: dec = 7'b1000110;  4'hD: dec = 7'b0100001;
            4'hE: dec = 7'b0000110;  default: dec = 7'b0001110;
        endcase
    endfunction

    // Position p counts cycles within a frame of 4*(cd+gc); digit and phase fall out by division.
    task automatic model_step(inout mdl_t m);
        int   slot, frame, d, w, msd;
        bit   commit, acc, show;
        logic [3:0] nib;
        slot  = m.cd + m.gc;
        frame = 4 * slot;
        if (rst) begin
            m.act = 0; m.p = 0; m.shadow = 16'h0; m.pend = 16'h0; m.full = 0; m.fd = 0;
            m.seg = 7'h7F; m.leds = 4'h0;
            return;
        end
        commit = m.full && (m.fd || !en);
        acc    = dv && !m.full;
        if (commit) begin m.shadow = m.pend; m.full = 0; end
        if (acc) begin m.pend = din; m.full = 1; end
        if (!en) begin
            m.act = 0; m.p = 0; m.fd = 0; m.seg = 7'h7F; m.leds = 4'h0;
            return;
        end
        if (!m.act) begin m.act = 1; m.p = 0; end
        else m.p = (m.p + 1) % frame;
        d    = m.p / slot;
        w    = m.p % slot;
        m.fd = (m.p == frame - 1);
        show = (w < m.cd);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int i = 0; i < 4; i++) if (((m.shadow >> (4 * i)) & 16'hF) != 16'h0) msd = i;
        if (d > msd) show = 0;
`else
        msd = 3;
        if (d > msd) show = 0;
`endif
        nib    = 4'((m.shadow >> (4 * d)) & 16'hF);
        m.seg  = show ? dec(nib) : 7'h7F;
        m.leds = show ? 4'(1 << d) : 4'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_seg",   32'(seg_a), 32'(ma.seg));
        chk("a_leds",  32'(leds_a), 32'(ma.leds));
        chk("a_frame", 32'(fd_a), 32'(ma.fd));
        chk("a_ready", 32'(bus_a.data_ready), 32'(!ma.full));
        chk("b_seg",   32'(seg_b), 32'(mb.seg));
        chk("b_leds",  32'(leds_b), 32'(mb.leds));
        chk("b_frame", 32'(fd_b), 32'(mb.fd));
        chk("b_ready", 32'(bus_b.data_ready), 32'(!mb.full));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step(ma);
            model_step(mb);
            cyc_no++;
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        bit hold;
        int mk;
        logic [15:0] mask;
        ma = '{cd: 4, gc: 1, p: 0, act: 0, full: 0, fd: 0, shadow: 16'h0, pend: 16'h0, seg: 7'h7F, leds: 4'h0};
        mb = '{cd: 3, gc: 0, p: 0, act: 0, full: 0, fd: 0, shadow: 16'h0, pend: 16'h0, seg: 7'h7F, leds: 4'h0};

        rst = 1'b1; en = 1'b1;
        step(3);
        chk("rst_seg",   32'(seg_a), 32'h7F);
        chk("rst_leds",  32'(leds_a), 32'h0);
        chk("rst_ready", 32'(bus_a.data_ready), 32'h1);
        rst = 1'b0;
        step(1);
        chk("first_led1", 32'(leds_a), 32'h1);
        chk("first_seg",  32'(seg_a), 32'(7'b1000000));
        step(39);

        din = 16'h1234; dv = 1'b1;
        step(1);
        dv = 1'b0;
        chk("load_ready_low", 32'(bus_a.data_ready), 32'h0);
        step(45);

        din = 16'h5A5A; dv = 1'b1;
        step(1);
        din = 16'hABCD;
        step(25);
        dv = 1'b0;
        step(50);

        step(11);
        en = 1'b0;
        step(7);
        en = 1'b1;
        step(30);

        din = 16'h5555; dv = 1'b1;
        step(1);
        dv = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        chk("midrst_ready", 32'(bus_a.data_ready), 32'h1);
        chk("midrst_leds",  32'(leds_a), 32'h0);
        rst = 1'b0;
        step(30);

        din = 16'h0050; dv = 1'b1;
        step(1);
        dv = 1'b0;
        step(45);
        din = 16'h0000; dv = 1'b1;
        step(1);
        dv = 1'b0;
        step(45);

        for (int i = 0; i < 800; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 24) != 0);
            hold = dv && (ma.full || mb.full);
            if (!hold) begin
                dv = ($urandom_range(0, 2) == 0);
                mk = $urandom_range(0, 3);
                mask = (mk == 0) ? 16'hFFFF : (mk == 1) ? 16'h00FF : (mk == 2) ? 16'h000F : 16'h0000;
                din  = 16'($urandom) & mask;
            end
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
